piso_shift_reg: RTL and testbench

PISO_SHIFT_REG -- requirements
Module: piso_shift_reg

---
 rtl/piso_shift_reg.sv | 106 ++++++++++
 tb/tb_piso_shift_reg.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/piso_shift_reg.sv
// piso_shift_reg: parallel-in / serial-out shift register with valid/ready
// handshakes on both sides. Back-to-back words stream with no idle cycle.
//
// Ports:
//   clk        rising-edge clock for all state
//   areset_n   asynchronous active-low reset
//   abort      synchronous clear, drops the word in progress
//   load_valid parallel word offered
//   load_data  parallel word (WIDTH bits)
//   load_ready block accepts a word this cycle (combinational)
//   ser_ready  downstream accepts the current serial bit
//   ser_valid  ser_bit is valid (combinational from state)
//   ser_bit    current serial bit (combinational from q)
//   ser_last   current bit is the final bit of the word
//   q          shift-register contents
//   bit_cnt    bits remaining in the current word
module piso_shift_reg #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          LSB_FIRST = 1'b1,
  parameter bit          FILL      = 1'b0,
  localparam int unsigned CW       = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             areset_n,
  input  logic             abort,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  input  logic             ser_ready,
  output logic             ser_valid,
  output logic             ser_bit,
  output logic             ser_last,
  output logic [WIDTH-1:0] q,
  output logic [CW-1:0]    bit_cnt
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0] q_shift;
  logic [CW-1:0]    cnt_nxt;
  logic             load_hs;
  logic             ser_hs;

  // State, shift register and bit counter
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state   <= IDLE;
      q       <= '0;
      bit_cnt <= '0;
    end else begin
      state   <= state_nxt;
      q       <= q_nxt;
      bit_cnt <= cnt_nxt;
    end
  end

  // Handshake outputs and next-state logic
  always_comb begin
    state_nxt  = state;
    q_nxt      = q;
    cnt_nxt    = bit_cnt;
    ser_valid  = 1'b0;
    ser_last   = 1'b0;
    ser_bit    = 1'b0;
    load_ready = 1'b0;

    q_shift = LSB_FIRST ? {FILL, q[WIDTH-1:1]} : {q[WIDTH-2:0], FILL};

    if (state == SHIFT) begin
      ser_valid  = 1'b1;
      ser_last   = (bit_cnt == CW'(1));
      ser_bit    = LSB_FIRST ? q[0] : q[WIDTH-1];
      // A new word may only enter as the final bit leaves.
      load_ready = ser_last & ser_ready & ~abort;
    end else begin
      load_ready = ~abort;
    end

    load_hs = load_valid & load_ready;
    ser_hs  = ser_valid & ser_ready;

    // Priority: abort, then load (wins over a final-bit shift), then shift.
    if (abort) begin
      state_nxt = IDLE;
      q_nxt     = '0;
      cnt_nxt   = '0;
    end else if (load_hs) begin
      state_nxt = SHIFT;
      q_nxt     = load_data;
      cnt_nxt   = CW'(WIDTH);
    end else if (ser_hs) begin
      q_nxt   = q_shift;
      cnt_nxt = bit_cnt - CW'(1);
      if (ser_last) begin
        state_nxt = IDLE;
      end
    end
  end

endmodule

// File: tb/tb_piso_shift_reg.sv
// Bench for piso_shift_reg: two instances share the stimulus, one LSB-first
// with FILL=0 and one MSB-first with FILL=1. A word-level model (word held,
// count of bits already sent) predicts every output each cycle.
module tb_piso_shift_reg;

  localparam int unsigned W = 8;

  logic         clk        = 1'b0;
  logic         areset_n   = 1'b0;
  logic         abort      = 1'b0;
  logic         load_valid = 1'b0;
  logic [W-1:0] load_data  = '0;
  logic         ser_ready  = 1'b0;

  logic [1:0]   lr, sv, sb, sl;
  logic [W-1:0] q0, q1;
  logic [3:0]   bc0, bc1;

  int compared   = 0;
  int mismatched = 0;

  // Reference model state per instance (0: LSB-first/FILL 0, 1: MSB-first/FILL 1)
  logic         m_busy [2];
  logic         m_zero [2];
  logic [W-1:0] m_word [2];
  int           m_n    [2];

  piso_shift_reg #(.WIDTH(W), .LSB_FIRST(1'b1), .FILL(1'b0)) dut_lsb (
    .clk(clk), .areset_n(areset_n), .abort(abort),
    .load_valid(load_valid), .load_data(load_data), .load_ready(lr[0]),
    .ser_ready(ser_ready), .ser_valid(sv[0]), .ser_bit(sb[0]),
    .ser_last(sl[0]), .q(q0), .bit_cnt(bc0)
  );

  piso_shift_reg #(.WIDTH(W), .LSB_FIRST(1'b0), .FILL(1'b1)) dut_msb (
    .clk(clk), .areset_n(areset_n), .abort(abort),
    .load_valid(load_valid), .load_data(load_data), .load_ready(lr[1]),
    .ser_ready(ser_ready), .ser_valid(sv[1]), .ser_bit(sb[1]),
    .ser_last(sl[1]), .q(q1), .bit_cnt(bc1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_busy[k] = 1'b0;
      m_zero[k] = 1'b1;
      m_word[k] = '0;
      m_n[k]    = 0;
    end
  endtask

  // Register contents = loaded word moved by the number of bits sent,
  // with the fill value occupying the vacated positions.
  function automatic logic [W-1:0] exp_q(input int k);
    logic [W-1:0] r;
    logic [W-1:0] mask;
    if (m_zero[k]) return '0;
    mask = '1;
    if (k == 0) begin
      r = m_word[k] >> m_n[k];
    end else begin
      r    = m_word[k] << m_n[k];
      mask = mask << m_n[k];
      r    = r | ~mask;
    end
    return r;
  endfunction

  function automatic logic exp_lr(input int k);
    if (m_busy[k]) return (m_n[k] == W - 1) && ser_ready && !abort;
    return !abort;
  endfunction

  task automatic check_outputs(input string tag);
    logic         e_bit;
    logic [W-1:0] o_q;
    logic [3:0]   o_bc;
    for (int k = 0; k < 2; k++) begin
      o_q   = (k == 0) ? q0 : q1;
      o_bc  = (k == 0) ? bc0 : bc1;
      e_bit = 1'b0;
      if (m_busy[k]) e_bit = (k == 0) ? m_word[k][m_n[k]] : m_word[k][W-1-m_n[k]];
      chk($sformatf("%s/i%0d/load_ready", tag, k), W'(lr[k]), W'(exp_lr(k)));
      chk($sformatf("%s/i%0d/ser_valid", tag, k), W'(sv[k]), W'(m_busy[k]));
      chk($sformatf("%s/i%0d/ser_bit", tag, k), W'(sb[k]), W'(e_bit));
      chk($sformatf("%s/i%0d/ser_last", tag, k), W'(sl[k]), W'(m_busy[k] && m_n[k] == W - 1));
      chk($sformatf("%s/i%0d/q", tag, k), o_q, exp_q(k));
      chk($sformatf("%s/i%0d/bit_cnt", tag, k), W'(o_bc), m_busy[k] ? W'(W - m_n[k]) : '0);
    end
  endtask

  // Advance the model across one rising edge using the currently driven inputs
  task automatic model_step();
    logic take;
    for (int k = 0; k < 2; k++) begin
      take = load_valid && exp_lr(k);
      if (abort) begin
        m_busy[k] = 1'b0;
        m_zero[k] = 1'b1;
        m_n[k]    = 0;
      end else if (take) begin
        m_busy[k] = 1'b1;
        m_zero[k] = 1'b0;
        m_word[k] = load_data;
        m_n[k]    = 0;
      end else if (m_busy[k] && ser_ready) begin
        m_n[k]++;
        if (m_n[k] == W) m_busy[k] = 1'b0;
      end
    end
  endtask

  task automatic cycle(input logic lv, input logic [W-1:0] ld, input logic sr,
                       input logic ab, input string tag);
    @(negedge clk);
    load_valid = lv;
    load_data  = ld;
    ser_ready  = sr;
    abort      = ab;
    #1;
    check_outputs(tag);
    model_step();
  endtask

  initial begin
    logic [W-1:0] pat;
    pat = 8'h2D;
    model_reset();

    // Reset state
    #12;
    check_outputs("reset");
    @(negedge clk);
    areset_n = 1'b1;

    // Single word, continuous ready: LSB 1,0,1,1,0,1,0,0 / MSB 0,0,1,0,1,1,0,1
    cycle(1'b1, 8'h2D, 1'b1, 1'b0, "load1");
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 8'h00, 1'b1, 1'b0, "word1");
      chk($sformatf("seq_lsb_bit%0d", i), W'(sb[0]), W'(pat[i]));
      chk($sformatf("seq_msb_bit%0d", i), W'(sb[1]), W'(pat[W-1-i]));
      if (i == 4) chk("q_after4_lsb", q0, 8'h02);
    end
    cycle(1'b0, 8'h00, 1'b1, 1'b0, "idle1");
    chk("idle_q_lsb", q0, 8'h00);
    chk("idle_q_msb_fill", q1, 8'hFF);

    // Back-to-back words with load_valid held
    cycle(1'b1, 8'h2D, 1'b1, 1'b0, "b2b_load");
    for (int i = 0; i < 8; i++) cycle(1'b1, 8'hFF, 1'b1, 1'b0, "b2b_w1");
    for (int i = 0; i < 8; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, "b2b_w2");
    cycle(1'b0, 8'h00, 1'b1, 1'b0, "b2b_idle");

    // Stall after bit 3
    cycle(1'b1, 8'h2D, 1'b1, 1'b0, "stall_load");
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, "stall_pre");
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 8'h55, 1'b0, 1'b0, "stall_hold");
      chk("stall_cnt_lsb", W'(bc0), 8'd5);
    end
    for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, "stall_post");
    cycle(1'b0, 8'h00, 1'b1, 1'b0, "stall_idle");

    // Abort at bit_cnt 4 with a load offered
    cycle(1'b1, 8'hC3, 1'b1, 1'b0, "abort_load");
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, "abort_pre");
    cycle(1'b1, 8'hAA, 1'b1, 1'b1, "abort");
    cycle(1'b0, 8'h00, 1'b1, 1'b0, "abort_after");
    chk("abort_q_msb", q1, 8'h00);
    chk("abort_cnt_msb", W'(bc1), 8'd0);

    // Asynchronous reset mid-cycle at bit_cnt 6
    cycle(1'b1, 8'h96, 1'b1, 1'b0, "arst_load");
    for (int i = 0; i < 2; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, "arst_pre");
    @(negedge clk);
    load_valid = 1'b0;
    ser_ready  = 1'b1;
    abort      = 1'b0;
    #2;
    areset_n = 1'b0;
    #1;
    model_reset();
    check_outputs("arst_async");
    @(negedge clk);
    areset_n = 1'b1;
    cycle(1'b1, 8'h3C, 1'b1, 1'b0, "arst_reload");
    for (int i = 0; i < 9; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, "arst_word");

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 2) != 0), W'($urandom), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 31) == 0), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
